irq_ir_ctrl: RTL and testbench
==============================

# irq_ir_ctrl

Instruction-register and interrupt-injection stage sitting directly upstream of the T-state sequencer. It samples NMI/IRQ at instruction boundaries and latches the fetched opcode at the end of T1, substituting a forced BRK (0x00) when an interrupt or reset is pending. It supplies the sequencer's `onecycle`/`twocycle` predecode and the vector/B-flag/PC-hold controls used by the BRK microcode.

## Interface
- `NMI_VEC`, 16'hFFFA, NMI vector address
- `RST_VEC`, 16'hFFFC, reset vector address
- `IRQ_VEC`, 16'hFFFE, IRQ/BRK vector address

- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  reset; one clock, asynchronous, active-low
- `ready`  in  1  cycle enable; low = stall
- `t`  in  3  current T state from sequencer (T0=0 … T7=7)
- `t_next`  in  3  next T state from sequencer
- `data_in`  in  8  data bus (opcode during T1)
- `nmi_n`  in  1  async NMI, falling-edge triggered
- `irq_n`  in  1  async IRQ, level, active-low
- `i_flag`  in  1  P.I interrupt-disable flag
- `ir`  out  8  latched opcode
- `sync`  out  1  opcode-fetch cycle indicator
- `onecycle`  out  1  predecode to sequencer
- `twocycle`  out  1  predecode to sequencer
- `int_kind`  out  2  00 BRK, 01 IRQ, 10 NMI, 11 RESET
- `vector`  out  16  vector for current `int_kind`
- `b_flag`  out  1  B bit value to push
- `pc_hold`  out  1  suppress PC increment (forced BRK)

## Operation
- `sync` = (`t`==T1), combinational.
- NMI path: `nmi_n` → 2-flop synchronizer → 3rd flop; falling edge on synchronized signal sets `nmi_pend`. Synchronizer/edge flops run every clock, ignoring `ready`.
- IRQ level: `irq_lvl` = ~`irq_n_sync` & ~`i_flag` (same 2-flop sync depth).
- Boundary sample: on a `ready` edge with `t_next`==T1, `int_req` <= `nmi_pend` | `irq_lvl`; `req_nmi` <= `nmi_pend`.
- Opcode latch: on a `ready` edge with `t`==T1:
  - `int_req`=1: `ir`<=8'h00, `int_kind`<= NMI if `req_nmi` else IRQ, `int_active`<=1; NMI selection clears `nmi_pend`.
  - else: `ir`<=`data_in`, `int_kind`<=BRK, `int_active`<=0.
- Priority: NMI > IRQ. IRQ is never latched pending; if the level drops before the boundary sample, it is lost.
- A new NMI edge in the same cycle as the clear leaves `nmi_pend` set (set wins).
- `vector`: NMI→`NMI_VEC`, RESET→`RST_VEC`, IRQ/BRK→`IRQ_VEC`.
- `b_flag` = (`int_kind`==BRK). `pc_hold` = `int_active`.
- Predecode (from `data_in` while `sync`; from `ir` otherwise; forced to 0 when `int_req` during T1):
  - `onecycle` = `data_in[1:0]`==2'b11.
  - `twocycle` = low nibble 8 except 08/28/48/68; 0A/2A/4A/6A; 8A–EA even high nibble (8A,9A,AA,BA,CA,DA,EA,FA excluded unless in {8A,9A,AA,BA,CA,EA}); immediates x9 with even high nibble; A0, A2, C0, E0.

## Timing
- Reset values: `ir`=8'h00, `int_kind`=RESET, `int_active`=1, `nmi_pend`=0, `int_req`=0, synchronizer flops=1. Outputs are valid immediately (sequencer restarts at T2 and executes the reset BRK).
- `ready` low: `ir`, `int_kind`, `int_active`, `int_req`, and `nmi_pend` clear hold; synchronizer and edge detection continue.
- NMI latency: `nmi_n` fall → `nmi_pend` set on 3rd rising edge.
- `ir`/`int_kind` update 1 clock after the T1 cycle edge and remain stable through the instruction.
- `reset_n` asserted mid-instruction returns all state to reset values asynchronously; any pending NMI is discarded.

## Test plan
- Reset release with `data_in`=8'hA9 at first T1 → `ir`=00, `int_kind`=11, `vector`=FFFC, `pc_hold`=1. Next T1 with A9 → `ir`=A9, `twocycle`=1, `int_kind`=00.
- `irq_n`=0, `i_flag`=0, held across a boundary → next T1 gives `ir`=00, `int_kind`=01, `vector`=FFFE, `b_flag`=0. Repeat with `i_flag`=1 → opcode latched normally.
- `nmi_n` 1→0 pulse of 2 clocks mid-instruction → `ir`=00, `int_kind`=10, `vector`=FFFA; following instruction is not interrupted (pend cleared).
- NMI edge and IRQ low simultaneously → NMI serviced first. IRQ serviced at the next boundary if still low and `i_flag`=0.
- `ready` low for 5 clocks during T1 with an NMI edge in that window → `ir` unchanged until `ready` returns. NMI is still taken at the following boundary.
- Natural `data_in`=00 at T1 → `int_kind`=00, `b_flag`=1, `pc_hold`=0. `data_in`=8'h03 → `onecycle`=1.

Source files
------------

// File: rtl/irq_ir_ctrl_if.sv
// Sequencer-facing bundle for the IR/interrupt-injection stage.
// slave = the irq_ir_ctrl block itself; master = the T-state sequencer side.
interface irq_ir_ctrl_if;
    logic        ready;
    logic [2:0]  t;
    logic [2:0]  t_next;
    logic [7:0]  data_in;
    logic        nmi_n;
    logic        irq_n;
    logic        i_flag;

    logic [7:0]  ir;
    logic        sync;
    logic        onecycle;
    logic        twocycle;
    logic [1:0]  int_kind;
    logic [15:0] vector;
    logic        b_flag;
    logic        pc_hold;

    modport slave (
        input  ready, t, t_next, data_in, nmi_n, irq_n, i_flag,
        output ir, sync, onecycle, twocycle, int_kind, vector, b_flag, pc_hold
    );

    modport master (
        output ready, t, t_next, data_in, nmi_n, irq_n, i_flag,
        input  ir, sync, onecycle, twocycle, int_kind, vector, b_flag, pc_hold
    );
endinterface

// File: rtl/irq_ir_ctrl.sv
// Opcode latch with NMI/IRQ/reset BRK injection; ir/int_kind update on the T1 edge.
// ready low stalls all instruction state; NMI/IRQ synchronizers keep running.
module irq_ir_ctrl #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic         clk,
    input  logic         reset_n,
    irq_ir_ctrl_if.slave bus
);

    localparam logic [2:0] T1        = 3'd1;
    localparam logic [1:0] KIND_BRK  = 2'b00;
    localparam logic [1:0] KIND_IRQ  = 2'b01;
    localparam logic [1:0] KIND_NMI  = 2'b10;
    localparam logic [1:0] KIND_RST  = 2'b11;

    logic       r_nmi_s1, r_nmi_s2, r_nmi_s3;
    logic       r_irq_s1, r_irq_s2;
    logic       r_nmi_pend;
    logic       r_int_req;
    logic       r_req_nmi;
    logic [7:0] r_ir;
    logic [1:0] r_int_kind;
    logic       r_int_active;

    logic       w_nmi_fall;
    logic       w_irq_lvl;
    logic       w_boundary;
    logic       w_latch;
    logic       w_take_nmi;
    logic       w_sync;
    logic       w_force;
    logic [7:0] w_op;
    logic [3:0] w_hi;
    logic [3:0] w_lo;
    logic       w_two;

    // Synchronizers are free-running so edges seen during a stall are not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nmi_s1 <= 1'b1;
            r_nmi_s2 <= 1'b1;
            r_nmi_s3 <= 1'b1;
            r_irq_s1 <= 1'b1;
            r_irq_s2 <= 1'b1;
        end else begin
            r_nmi_s1 <= bus.nmi_n;
            r_nmi_s2 <= r_nmi_s1;
            r_nmi_s3 <= r_nmi_s2;
            r_irq_s1 <= bus.irq_n;
            r_irq_s2 <= r_irq_s1;
        end
    end

    assign w_nmi_fall = r_nmi_s3 & ~r_nmi_s2;
    assign w_irq_lvl  = ~r_irq_s2 & ~bus.i_flag;
    assign w_boundary = bus.ready & (bus.t_next == T1);
    assign w_latch    = bus.ready & (bus.t == T1);
    assign w_take_nmi = w_latch & r_int_req & r_req_nmi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nmi_pend   <= 1'b0;
            r_int_req    <= 1'b0;
            r_req_nmi    <= 1'b0;
            r_ir         <= 8'h00;
            r_int_kind   <= KIND_RST;
            r_int_active <= 1'b1;
        end else begin
            // A fresh edge coinciding with the service clear must survive.
            if (w_nmi_fall) begin
                r_nmi_pend <= 1'b1;
            end else if (w_take_nmi) begin
                r_nmi_pend <= 1'b0;
            end

            if (w_boundary) begin
                r_int_req <= r_nmi_pend | w_irq_lvl;
                r_req_nmi <= r_nmi_pend;
            end

            if (w_latch) begin
                if (r_int_req) begin
                    r_ir         <= 8'h00;
                    r_int_kind   <= r_req_nmi ? KIND_NMI : KIND_IRQ;
                    r_int_active <= 1'b1;
                end else begin
                    r_ir         <= bus.data_in;
                    r_int_kind   <= KIND_BRK;
                    r_int_active <= 1'b0;
                end
            end
        end
    end

    // Predecode looks at the bus during the fetch so the sequencer can act in T1.
    assign w_sync  = (bus.t == T1);
    assign w_force = w_sync & r_int_req;
    assign w_op    = w_sync ? bus.data_in : r_ir;
    assign w_hi    = w_op[7:4];
    assign w_lo    = w_op[3:0];

    always_comb begin
        w_two = 1'b0;
        case (w_lo)
            4'h8: w_two = w_hi[0] | w_hi[3];
            4'hA: w_two = (~w_hi[3] & ~w_hi[0]) |
                          (w_hi[3] & (w_hi != 4'hD) & (w_hi != 4'hF));
            4'h9: w_two = ~w_hi[0];
            4'h0: w_two = (w_hi == 4'hA) | (w_hi == 4'hC) | (w_hi == 4'hE);
            4'h2: w_two = (w_hi == 4'hA);
            default: w_two = 1'b0;
        endcase
    end

    always_comb begin
        bus.vector = IRQ_VEC;
        case (r_int_kind)
            KIND_NMI: bus.vector = NMI_VEC;
            KIND_RST: bus.vector = RST_VEC;
            default:  bus.vector = IRQ_VEC;
        endcase
    end

    assign bus.ir       = r_ir;
    assign bus.int_kind = r_int_kind;
    assign bus.sync     = w_sync;
    assign bus.onecycle = ~w_force & (w_op[1:0] == 2'b11);
    assign bus.twocycle = ~w_force & w_two;
    assign bus.b_flag   = (r_int_kind == KIND_BRK);
    assign bus.pc_hold  = r_int_active;

endmodule

// File: tb/tb_irq_ir_ctrl.sv
// Directed test-plan scenarios followed by randomized traffic, all checked against a
// cycle-indexed reference built from input histories and the interrupt rules.
module tb_irq_ir_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    irq_ir_ctrl_if bus();

    irq_ir_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_ir;
    logic [1:0] m_kind;
    logic       m_act, m_pend, m_req, m_reqnmi;
    bit         nh[$];
    bit         ih[$];
    logic [2:0] seq_t;
    logic [2:0] seq_L;
    logic [2:0] fix_L;
    logic [7:0] saved_ir;

    function automatic bit two_ref(input logic [7:0] op);
        return op inside {8'h18, 8'h38, 8'h58, 8'h78, 8'h88, 8'h98, 8'hA8, 8'hB8,
                          8'hC8, 8'hD8, 8'hE8, 8'hF8, 8'h0A, 8'h2A, 8'h4A, 8'h6A,
                          8'h8A, 8'h9A, 8'hAA, 8'hBA, 8'hCA, 8'hEA, 8'h09, 8'h29,
                          8'h49, 8'h69, 8'h89, 8'hA9, 8'hC9, 8'hE9, 8'hA0, 8'hA2,
                          8'hC0, 8'hE0};
    endfunction

    function automatic logic [15:0] vec_ref(input logic [1:0] k);
        if (k == 2'b10) return 16'hFFFA;
        if (k == 2'b11) return 16'hFFFC;
        return 16'hFFFE;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ir = 8'h00; m_kind = 2'b11; m_act = 1'b1;
        m_pend = 1'b0; m_req = 1'b0; m_reqnmi = 1'b0;
        nh.delete(); ih.delete();
        repeat (4) begin nh.push_back(1'b1); ih.push_back(1'b1); end
    endtask

    // One rising edge of the reference: n[k-3]=1,n[k-2]=0 is an edge visible at edge k.
    task automatic model_edge();
        bit fall, lvl, clr;
        logic nreq, nreqnmi;
        if (!reset_n) begin
            model_reset();
            return;
        end
        nh.push_back(bus.nmi_n);
        ih.push_back(bus.irq_n);
        if (nh.size() > 8) void'(nh.pop_front());
        if (ih.size() > 8) void'(ih.pop_front());
        fall = nh[$-3] && !nh[$-2];
        lvl  = !ih[$-2] && !bus.i_flag;
        clr  = 1'b0;
        nreq = m_req; nreqnmi = m_reqnmi;
        if (bus.ready && bus.t_next == 3'd1) begin
            nreq = m_pend | lvl;
            nreqnmi = m_pend;
        end
        if (bus.ready && bus.t == 3'd1) begin
            if (m_req) begin
                m_ir = 8'h00; m_kind = m_reqnmi ? 2'b10 : 2'b01; m_act = 1'b1; clr = m_reqnmi;
            end else begin
                m_ir = bus.data_in; m_kind = 2'b00; m_act = 1'b0;
            end
        end
        m_req = nreq; m_reqnmi = nreqnmi;
        if (fall) m_pend = 1'b1;
        else if (clr) m_pend = 1'b0;
        if (bus.ready) begin
            if (seq_t == 3'd1) seq_L = (fix_L != 3'd0) ? fix_L : 3'($urandom_range(2, 5));
            seq_t = (seq_t == seq_L) ? 3'd1 : seq_t + 3'd1;
        end
    endtask

    task automatic apply();
        bus.t      = seq_t;
        bus.t_next = (seq_t == seq_L) ? 3'd1 : seq_t + 3'd1;
    endtask

    task automatic check_all();
        logic [7:0] op;
        bit e_sync, forced;
        e_sync = (bus.t == 3'd1);
        op     = e_sync ? bus.data_in : m_ir;
        forced = e_sync && m_req;
        chk("sync",     16'(bus.sync),     16'(e_sync));
        chk("ir",       16'(bus.ir),       16'(m_ir));
        chk("int_kind", 16'(bus.int_kind), 16'(m_kind));
        chk("vector",   bus.vector,        vec_ref(m_kind));
        chk("b_flag",   16'(bus.b_flag),   16'(m_kind == 2'b00));
        chk("pc_hold",  16'(bus.pc_hold),  16'(m_act));
        chk("onecycle", 16'(bus.onecycle), 16'(!forced && op[1:0] == 2'b11));
        chk("twocycle", 16'(bus.twocycle), 16'(!forced && two_ref(op)));
    endtask

    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        apply();
    endtask

    task automatic run_to_t1();
        for (int i = 0; i < 40 && seq_t != 3'd1; i++) cycle();
        #1 chk("reach_t1", 16'(bus.sync), 16'h0001);
    endtask

    task automatic latch(input logic [7:0] d);
        bus.ready = 1'b1;
        bus.data_in = d;
        cycle();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        seq_t = 3'd2;
        seq_L = (fix_L != 3'd0) ? fix_L : 3'd3;
        apply();
        #1;
        chk("rst_ir",      16'(bus.ir),       16'h0000);
        chk("rst_kind",    16'(bus.int_kind), 16'h0003);
        chk("rst_vector",  bus.vector,        16'hFFFC);
        chk("rst_pc_hold", 16'(bus.pc_hold),  16'h0001);
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.ready = 1'b1; bus.data_in = 8'hA9;
        bus.nmi_n = 1'b1; bus.irq_n = 1'b1; bus.i_flag = 1'b0;
        fix_L = 3'd6; seq_t = 3'd2; seq_L = 3'd6;
        apply();
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset BRK, then a normal fetch.
        run_to_t1();
        chk("t1_rst_ir", 16'(bus.ir), 16'h0000);
        chk("t1_rst_kind", 16'(bus.int_kind), 16'h0003);
        chk("t1_rst_vec", bus.vector, 16'hFFFC);
        latch(8'hA9);
        chk("a9_ir", 16'(bus.ir), 16'h00A9);
        chk("a9_two", 16'(bus.twocycle), 16'h0001);
        chk("a9_kind", 16'(bus.int_kind), 16'h0000);

        // IRQ taken, then masked.
        bus.irq_n = 1'b0;
        run_to_t1();
        chk("irq_forced_two", 16'(bus.twocycle), 16'h0000);
        latch(8'hA9);
        chk("irq_ir", 16'(bus.ir), 16'h0000);
        chk("irq_kind", 16'(bus.int_kind), 16'h0001);
        chk("irq_vec", bus.vector, 16'hFFFE);
        chk("irq_bflag", 16'(bus.b_flag), 16'h0000);
        bus.i_flag = 1'b1;
        run_to_t1();
        latch(8'h18);
        chk("masked_ir", 16'(bus.ir), 16'h0018);
        chk("masked_kind", 16'(bus.int_kind), 16'h0000);
        bus.irq_n = 1'b1; bus.i_flag = 1'b0;

        // NMI pulse, serviced once.
        bus.nmi_n = 1'b0; cycle(); cycle(); bus.nmi_n = 1'b1;
        run_to_t1();
        latch(8'hA9);
        chk("nmi_ir", 16'(bus.ir), 16'h0000);
        chk("nmi_kind", 16'(bus.int_kind), 16'h0002);
        chk("nmi_vec", bus.vector, 16'hFFFA);
        run_to_t1();
        latch(8'hEA);
        chk("post_nmi_ir", 16'(bus.ir), 16'h00EA);
        chk("post_nmi_kind", 16'(bus.int_kind), 16'h0000);

        // NMI beats IRQ; IRQ follows.
        bus.nmi_n = 1'b0; bus.irq_n = 1'b0; cycle(); cycle(); bus.nmi_n = 1'b1;
        run_to_t1();
        latch(8'hA9);
        chk("prio_first", 16'(bus.int_kind), 16'h0002);
        run_to_t1();
        latch(8'hA9);
        chk("prio_second", 16'(bus.int_kind), 16'h0001);
        bus.irq_n = 1'b1;

        // Stall in T1 with an NMI edge inside the window.
        run_to_t1();
        bus.ready = 1'b0; bus.nmi_n = 1'b0; bus.data_in = 8'h55;
        saved_ir = bus.ir;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus.nmi_n = 1'b1;
            cycle();
            #1 chk("stall_ir", 16'(bus.ir), 16'(saved_ir));
        end
        latch(8'h69);
        chk("stall_latch_ir", 16'(bus.ir), 16'h0069);
        run_to_t1();
        latch(8'hA9);
        chk("stall_nmi_kind", 16'(bus.int_kind), 16'h0002);

        // Natural BRK and a one-cycle opcode.
        run_to_t1();
        latch(8'h00);
        chk("brk_kind", 16'(bus.int_kind), 16'h0000);
        chk("brk_bflag", 16'(bus.b_flag), 16'h0001);
        chk("brk_pc_hold", 16'(bus.pc_hold), 16'h0000);
        run_to_t1();
        bus.data_in = 8'h03;
        #1 chk("one_sync", 16'(bus.onecycle), 16'h0001);
        latch(8'h03);
        chk("one_ir", 16'(bus.onecycle), 16'h0001);

        // Reset mid-instruction discards a pending NMI.
        bus.nmi_n = 1'b0; cycle(); cycle(); bus.nmi_n = 1'b1; cycle();
        do_reset();
        run_to_t1();
        latch(8'h4C);
        run_to_t1();
        latch(8'h4C);
        chk("rst_drop_nmi_kind", 16'(bus.int_kind), 16'h0000);
        chk("rst_drop_nmi_ir", 16'(bus.ir), 16'h004C);

        // Randomized traffic.
        fix_L = 3'd0;
        for (int i = 0; i < 1500; i++) begin
            bus.ready   = ($urandom_range(0, 7) != 0);
            bus.data_in = 8'($urandom);
            if ($urandom_range(0, 40) == 0) bus.i_flag = ~bus.i_flag;
            if ($urandom_range(0, 20) == 0) bus.irq_n = ~bus.irq_n;
            if (bus.nmi_n) bus.nmi_n = ($urandom_range(0, 30) != 0);
            else           bus.nmi_n = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
